// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: captures one load/store, waits LATENCY cycles,
// then performs the access on a little-endian word array and pulses Ready (and Fault on reject).
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Fault,
  output logic        Busy
);
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  req_t live, cap, cur;
  logic start, fire, bad;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0] lane;
  logic [NUM_LANES-1:0] be;
  logic [NUM_LANES-1:0][7:0] wl, word;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] rd_ext;
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  assign live  = '{rd: MemoryRead, wr: MemoryWrite, size: Size, sgn: Signed,
                   addr: Address, wdata: WriteData};
  assign start = MemoryRead | MemoryWrite;
  // With LATENCY=0 the access completes on the capture edge, so use the live request in IDLE.
  assign cur   = (state == IDLE) ? live : cap;
  assign idx   = cur.addr[ADDR_WIDTH+1:2];
  assign lane  = cur.addr[1:0];
  assign Busy  = (state != IDLE);

  assign bad = (cur.rd & cur.wr)
             | (cur.size == 2'b11)
             | ((cur.size == 2'b01) & cur.addr[0])
             | ((cur.size == 2'b10) & (|cur.addr[1:0]))
             | (|cur.addr[31:ADDR_WIDTH+2]);

  // Store lane enables and data steering: the low byte/half of WriteData lands on the addressed lanes.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    assign be[l] = (cur.size == 2'b00) ? (lane == LN) :
                   (cur.size == 2'b01) ? (lane[1] == LN[1]) : 1'b1;
    assign wl[l] = (cur.size == 2'b00) ? cur.wdata[7:0] :
                   (cur.size == 2'b01) ? cur.wdata[8*(l%2) +: 8] : cur.wdata[8*l +: 8];
  end

  assign word = mem[idx];
  assign rd_b = word[lane];
  assign rd_h = lane[1] ? word[3:2] : word[1:0];

  always_comb begin
    rd_ext = word;
    case (cur.size)
      2'b00:   rd_ext = {{24{cur.sgn & rd_b[7]}}, rd_b};
      2'b01:   rd_ext = {{16{cur.sgn & rd_h[15]}}, rd_h};
      default: rd_ext = word;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (LATENCY == 0) begin
          state_nx = RESP;
          fire     = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = LAT_M1;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nx = RESP;
        fire     = 1'b1;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap      <= '0;
      ReadData <= 32'd0;
      Ready    <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      Ready <= fire;
      Fault <= fire & bad;
      if (state == IDLE && start) cap <= live;
      if (fire && !bad && cur.rd) ReadData <= rd_ext;
    end
  end

  // Array is not reset; a reset arriving on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && fire && !bad && cur.wr)
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem[idx][l] <= wl[l];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, randomized traffic against a
// byte-arithmetic memory model, and hand sequences for reset-in-flight, busy-ignore and LATENCY=0.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        mr [2];
  logic        mw [2];
  logic        sg [2];
  logic [1:0]  sz [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdat [2];
  logic        rdy [2];
  logic        flt [2];
  logic        bsy [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [256];
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .MemoryRead(mr[0]), .MemoryWrite(mw[0]), .Size(sz[0]),
    .Signed(sg[0]), .Address(ad[0]), .WriteData(wd[0]), .ReadData(rdat[0]),
    .Ready(rdy[0]), .Fault(flt[0]), .Busy(bsy[0]));

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .MemoryRead(mr[1]), .MemoryWrite(mw[1]), .Size(sz[1]),
    .Signed(sg[1]), .Address(ad[1]), .WriteData(wd[1]), .ReadData(rdat[1]),
    .Ready(rdy[1]), .Fault(flt[1]), .Busy(bsy[1]));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    logic        flt;
    logic [31:0] q;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed arithmetic on whole words, independent of lane hardware.
  task automatic model(input logic r, input logic w, input logic [1:0] s, input logic g,
                       input logic [31:0] a, input logic [31:0] d, output logic f);
    int n, sh, idx;
    logic [31:0] wv, v;
    n = 1 << s;
    f = (r && w) || (s == 2'b11) || (a % n != 0) || (a >= 32'd1024);
    if (!f) begin
      idx = int'(a / 4);
      sh  = int'(a % 4);
      wv  = mdl[idx];
      if (r) begin
        if (n == 4) v = wv;
        else begin
          v = (wv >> (8 * sh)) & 32'((1 << (8 * n)) - 1);
          if (g && v >= 32'(1 << (8 * n - 1))) v = v - 32'(1 << (8 * n));
        end
        m_rd = v;
      end else begin
        for (int b = 0; b < n; b++)
          wv = (wv & ~(32'hFF << (8 * (sh + b)))) | (((d >> (8 * b)) & 32'hFF) << (8 * (sh + b)));
        mdl[idx] = wv;
      end
    end
  endtask

  task automatic run(input int k, input logic r, input logic w, input logic [1:0] s,
                     input logic g, input logic [31:0] a, input logic [31:0] d,
                     input logic fexp, input logic [31:0] qexp, input string tag);
    int lat;
    logic f, b1, after;
    logic [31:0] q;
    @(negedge clk);
    mr[k] = r; mw[k] = w; sz[k] = s; sg[k] = g; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    mr[k] = 1'b0; mw[k] = 1'b0;
    lat = 0; f = 1'b0; q = 32'd0; b1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) b1 = bsy[k];
      if (rdy[k]) begin
        lat = i; f = flt[k]; q = rdat[k];
        break;
      end
    end
    @(negedge clk);
    after = rdy[k] | bsy[k];
    chk({tag, " latency"}, 32'(lat), (k == 0) ? 32'd3 : 32'd1);
    chk({tag, " fault"}, {31'd0, f}, {31'd0, fexp});
    chk({tag, " rdata"}, q, qexp);
    chk({tag, " busy"}, {31'd0, b1}, 32'd1);
    chk({tag, " ready_drop"}, {31'd0, after}, 32'd0);
  endtask

  initial begin
    logic f;
    logic [1:0] s;
    logic [31:0] a, d;
    logic r, w, g;
    int nr, first;
    logic [31:0] q;

    for (int k = 0; k < 2; k++) begin
      mr[k] = 0; mw[k] = 0; sz[k] = 0; sg[k] = 0; ad[k] = 0; wd[k] = 0;
    end

    tbl[0]  = '{0, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 2'd2, 0, 32'h10,  32'h80FF7F01, 0, 32'hDEADBEEF};
    tbl[3]  = '{1, 0, 2'd0, 1, 32'h13,  32'h0,        0, 32'hFFFFFF80};
    tbl[4]  = '{1, 0, 2'd0, 0, 32'h10,  32'h0,        0, 32'h00000001};
    tbl[5]  = '{1, 0, 2'd1, 1, 32'h12,  32'h0,        0, 32'hFFFF80FF};
    tbl[6]  = '{1, 0, 2'd1, 0, 32'h10,  32'h0,        0, 32'h00007F01};
    tbl[7]  = '{1, 0, 2'd0, 1, 32'h11,  32'h0,        0, 32'h0000007F};
    tbl[8]  = '{0, 1, 2'd2, 0, 32'h10,  32'h11223344, 0, 32'h0000007F};
    tbl[9]  = '{0, 1, 2'd0, 0, 32'h11,  32'hFFFFFFAA, 0, 32'h0000007F};
    tbl[10] = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'h1122AA44};
    tbl[11] = '{0, 1, 2'd1, 0, 32'h12,  32'h12345566, 0, 32'h1122AA44};
    tbl[12] = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'h5566AA44};
    tbl[13] = '{1, 0, 2'd2, 0, 32'h2,   32'h0,        1, 32'h5566AA44};
    tbl[14] = '{1, 1, 2'd2, 0, 32'h10,  32'h0,        1, 32'h5566AA44};
    tbl[15] = '{1, 0, 2'd3, 0, 32'h10,  32'h0,        1, 32'h5566AA44};
    tbl[16] = '{1, 0, 2'd2, 0, 32'h400, 32'h0,        1, 32'h5566AA44};
    tbl[17] = '{1, 0, 2'd1, 1, 32'h11,  32'h0,        1, 32'h5566AA44};
    tbl[18] = '{0, 1, 2'd2, 0, 32'h0,   32'hCAFEF00D, 0, 32'h5566AA44};
    tbl[19] = '{0, 1, 2'd2, 0, 32'h400, 32'h0,        1, 32'h5566AA44};
    tbl[20] = '{1, 0, 2'd2, 0, 32'h0,   32'h0,        0, 32'hCAFEF00D};
    tbl[21] = '{0, 1, 2'd1, 0, 32'h13,  32'h0000FFFF, 1, 32'hCAFEF00D};
    tbl[22] = '{1, 0, 2'd2, 0, 32'h10,  32'h0,        0, 32'h5566AA44};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset rdata", rdat[0], 32'd0);
    chk("reset ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset fault", {31'd0, flt[0]}, 32'd0);
    chk("reset busy",  {31'd0, bsy[0]}, 32'd0);

    for (int i = 0; i < 23; i++)
      run(0, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d,
          tbl[i].flt, tbl[i].q, $sformatf("vec%0d", i));
    m_rd = 32'h5566AA44;

    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      model(0, 1, 2'd2, 0, 32'(i * 4), d, f);
      run(0, 0, 1, 2'd2, 0, 32'(i * 4), d, f, m_rd, $sformatf("init%0d", i));
    end

    for (int t = 0; t < 300; t++) begin
      nr = int'($urandom_range(0, 9));
      r = (nr < 5);
      w = (nr == 0) || (nr >= 5);
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      g = 1'($urandom);
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      d = $urandom;
      model(r, w, s, g, a, d, f);
      run(0, r, w, s, g, a, d, f, m_rd, $sformatf("rnd%0d", t));
    end

    // Reset while a store is waiting: store dropped, no Ready, ReadData cleared.
    model(0, 1, 2'd2, 0, 32'h20, 32'h55AA55AA, f);
    run(0, 0, 1, 2'd2, 0, 32'h20, 32'h55AA55AA, f, m_rd, "rst_pre");
    @(negedge clk);
    mw[0] = 1; sz[0] = 2'd2; ad[0] = 32'h20; wd[0] = 32'h1;
    @(posedge clk); #1;
    mw[0] = 0;
    @(negedge clk);
    chk("rst busy_wait", {31'd0, bsy[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy_after", {31'd0, bsy[0]}, 32'd0);
    chk("rst rdata", rdat[0], 32'd0);
    m_rd = 32'd0;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy[0]) nr++;
      @(negedge clk);
    end
    chk("rst no_ready", 32'(nr), 32'd0);
    model(1, 0, 2'd2, 0, 32'h20, 32'h0, f);
    run(0, 1, 0, 2'd2, 0, 32'h20, 32'h0, f, m_rd, "rst_old");

    // Inputs wiggled during WAIT must not disturb the captured load.
    model(0, 1, 2'd2, 0, 32'h40, 32'h01020304, f);
    run(0, 0, 1, 2'd2, 0, 32'h40, 32'h01020304, f, m_rd, "ign_pre");
    model(1, 0, 2'd2, 0, 32'h44, 32'h0, f);
    @(negedge clk);
    mr[0] = 1; sz[0] = 2'd2; ad[0] = 32'h44;
    @(posedge clk); #1;
    mr[0] = 0; mw[0] = 1; ad[0] = 32'h40; wd[0] = 32'hBAD0BAD0; sz[0] = 2'd0;
    nr = 0; first = 0; q = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rdy[0]) begin
        nr++;
        if (first == 0) begin first = i; q = rdat[0]; end
      end
      if (i == 3) mw[0] = 0;
    end
    chk("ign ready_count", 32'(nr), 32'd1);
    chk("ign latency", 32'(first), 32'd3);
    chk("ign rdata", q, m_rd);
    model(1, 0, 2'd2, 0, 32'h40, 32'h0, f);
    run(0, 1, 0, 2'd2, 0, 32'h40, 32'h0, f, m_rd, "ign_mem");

    // LATENCY=0 instance.
    run(1, 0, 1, 2'd2, 0, 32'h8, 32'h12345678, 0, 32'h0, "l0_sw");
    run(1, 0, 1, 2'd2, 0, 32'hC, 32'h0, 0, 32'h0, "l0_sw2");
    run(1, 1, 0, 2'd2, 0, 32'h8, 32'h0, 0, 32'h12345678, "l0_lw");
    run(1, 1, 0, 2'd0, 1, 32'hB, 32'h0, 0, 32'h00000012, "l0_lb");
    @(negedge clk);
    mr[1] = 1; sz[1] = 2'd2; ad[1] = 32'h8;
    @(posedge clk); #1;
    mr[1] = 0; mw[1] = 1; ad[1] = 32'hC; wd[1] = 32'hFFFFFFFF;
    nr = 0; first = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (rdy[1]) begin
        nr++;
        if (first == 0) first = i;
      end
      if (i == 1) mw[1] = 0;
    end
    chk("l0 ready_count", 32'(nr), 32'd1);
    chk("l0 latency", 32'(first), 32'd1);
    run(1, 1, 0, 2'd2, 0, 32'hC, 32'h0, 0, 32'h0, "l0_ign_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
